// File: rtl/fifo_wr_pkg.sv
// fifo_wr_pkg: shared state/mode enums and default widths for the FIFO burst writer
package fifo_wr_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int LEN_W_DEF  = 4;
  typedef enum logic [1:0] {IDLE = 2'b00, PUSH = 2'b01, DONE = 2'b10} state_t;
  typedef enum logic [1:0] {INC = 2'b00, CONST = 2'b01, LFSR = 2'b10, WALK = 2'b11} mode_t;
endpackage

// File: rtl/fifo_pattern_gen.sv
// fifo_pattern_gen: pattern register; wclk/rst, load (seed per mode), advance (step per mode), word_o current value
module fifo_pattern_gen
  import fifo_wr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              wclk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  mode_t             mode,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] word_o
);
  logic [DATA_W-1:0] pat_q, pat_d, step, init;
  always_comb begin
    // walking-one always starts at 1; LFSR cannot leave the all-zero state, so 0 is replaced by 1
    init = (mode == WALK || (mode == LFSR && seed == '0)) ? DATA_W'(1) : seed;
    step = mode == INC   ? pat_q + DATA_W'(1) :
           mode == CONST ? pat_q :
           mode == LFSR  ? {pat_q[DATA_W-2:0], pat_q[DATA_W-1] ^ pat_q[DATA_W-2]} :
                           {pat_q[DATA_W-2:0], pat_q[DATA_W-1]};
    pat_d = load ? init : advance ? step : pat_q;
  end
  always_ff @(posedge wclk or posedge rst)
    if (rst) pat_q <= '0;
    else pat_q <= pat_d;
  assign word_o = pat_q;
endmodule

// File: rtl/fifo_burst_writer.sv
// fifo_burst_writer: pushes a len-word patterned burst into a FIFO; start/len/mode/seed request, abort, full_in stall; we/data_out write port, busy/done status, sent_count/checksum summary
module fifo_burst_writer
  import fifo_wr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              wclk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              abort,
  input  logic              full_in,
  output logic              we,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic [LEN_W:0]    sent_count,
  output logic [DATA_W-1:0] checksum
);
  state_t            state_q, state_d;
  mode_t             mode_q, mode_d, gen_mode;
  logic [LEN_W:0]    rem_q, rem_d, sent_q, sent_d;
  logic [DATA_W-1:0] chk_q, chk_d;
  logic              accept;
  always_comb begin
    accept   = state_q == IDLE && start;
    we       = state_q == PUSH && !full_in;
    // the generator sees the incoming mode while loading, the latched one while advancing
    gen_mode = accept ? mode_t'(mode) : mode_q;
    mode_d   = accept ? mode_t'(mode) : mode_q;
    rem_d    = accept ? (len == '0 ? (LEN_W+1)'(1) << LEN_W : {1'b0, len}) :
               we     ? rem_q - (LEN_W+1)'(1) : rem_q;
    sent_d   = accept ? '0 : we ? sent_q + (LEN_W+1)'(1) : sent_q;
    chk_d    = accept ? '0 : we ? chk_q ^ data_out : chk_q;
    state_d  = state_q == IDLE ? (accept ? PUSH : IDLE) :
               state_q == PUSH ? ((we && rem_q == (LEN_W+1)'(1)) || abort ? DONE : PUSH) :
                                 IDLE;
  end
  always_ff @(posedge wclk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= INC;
      rem_q   <= '0;
      sent_q  <= '0;
      chk_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      sent_q  <= sent_d;
      chk_q   <= chk_d;
    end
  fifo_pattern_gen #(.DATA_W(DATA_W)) u_gen (
    .wclk    (wclk),
    .rst     (rst),
    .load    (accept),
    .advance (we),
    .mode    (gen_mode),
    .seed    (seed),
    .word_o  (data_out)
  );
  assign busy       = state_q == PUSH;
  assign done       = state_q == DONE;
  assign sent_count = sent_q;
  assign checksum   = chk_q;
endmodule

// File: tb/tb_fifo_burst_writer.sv
// tb_fifo_burst_writer: directed and randomized bursts checked against a word-list reference model
module tb_fifo_burst_writer;
  logic       wclk = 0, rst = 1, start = 0, abort = 0, full_in = 0;
  logic [3:0] len = 0, seed = 0;
  logic [1:0] mode = 0;
  logic       we, busy, done;
  logic [3:0] data_out, checksum;
  logic [4:0] sent_count;
  int cmp = 0, fails = 0;
  int ns;
  logic [3:0] cs;

  fifo_burst_writer dut (
    .wclk(wclk), .rst(rst), .start(start), .len(len), .mode(mode), .seed(seed),
    .abort(abort), .full_in(full_in), .we(we), .data_out(data_out), .busy(busy),
    .done(done), .sent_count(sent_count), .checksum(checksum)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] next_word(input logic [3:0] w, input int m);
    case (m)
      0: return w + 4'd1;
      1: return w;
      2: return {w[2:0], w[3] ^ w[2]};
      default: return {w[2:0], w[3]};
    endcase
  endfunction

  // one burst: ab = number of writes after which abort fires (0 = none), fmask = forced-full cycles
  task automatic burst(input int l, input int m, input logic [3:0] s, input int pct,
                       input logic [31:0] fmask, input int ab,
                       output int nsent, output logic [3:0] csum);
    logic [3:0] w[$];
    logic [3:0] x;
    int n, k, cyc;
    bit stop;
    n = (l == 0) ? 16 : l;
    x = (m == 3 || (m == 2 && s == 0)) ? 4'd1 : s;
    for (int i = 0; i < n; i++) begin
      w.push_back(x);
      x = next_word(x, m);
    end
    @(negedge wclk);
    start = 1; len = l[3:0]; mode = m[1:0]; seed = s; full_in = 0; abort = 0;
    #1 check("idle_we", we, 0);
    check("idle_busy", busy, 0);
    @(negedge wclk);
    start = 0;
    k = 0; cyc = 0; csum = 0; stop = 0;
    while (!stop && k < n && cyc < 400) begin
      full_in = (cyc < 32 && fmask[cyc]) || ($urandom_range(99) < pct);
      abort = (ab != 0 && k == ab - 1 && !full_in);
      start = 1'($urandom_range(1));
      #1 check("push_busy", busy, 1);
      check("push_we", we, !full_in);
      check("push_data", data_out, w[k]);
      check("push_sent", sent_count, k);
      check("push_chk", checksum, csum);
      if (!full_in) begin
        csum ^= w[k];
        k++;
        stop = abort;
      end
      @(negedge wclk);
      cyc++;
    end
    start = 0; full_in = 0; abort = 0;
    check("burst_len", k, (ab != 0) ? ab : n);
    #1 check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_we", we, 0);
    check("done_sent", sent_count, k);
    check("done_chk", checksum, csum);
    @(negedge wclk);
    #1 check("after_done", done, 0);
    check("after_busy", busy, 0);
    check("hold_sent", sent_count, k);
    check("hold_chk", checksum, csum);
    nsent = k;
  endtask

  initial begin
    #1 check("rst_we", we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sent", sent_count, 0);
    check("rst_chk", checksum, 0);
    check("rst_data", data_out, 0);
    @(negedge wclk);
    @(negedge wclk);
    rst = 0;
    abort = 1;
    @(negedge wclk);
    #1 check("abort_idle_busy", busy, 0);
    check("abort_idle_done", done, 0);
    abort = 0;

    burst(3, 0, 4'b1110, 0, 0, 0, ns, cs);
    check("inc_sent", ns, 3);
    check("inc_chk", cs, 4'b0001);
    burst(0, 3, 4'b1010, 0, 0, 0, ns, cs);
    check("walk_sent", sent_count, 5'b10000);
    check("walk_chk", checksum, 0);
    burst(4, 2, 4'b0000, 0, 0, 0, ns, cs);
    check("lfsr_chk", checksum, 4'b1110);
    burst(4, 1, 4'b0101, 0, 32'b1110, 0, ns, cs);
    check("const_sent", sent_count, 4);
    check("const_chk", checksum, 0);
    burst(8, 0, 4'd2, 0, 0, 3, ns, cs);
    check("abort_sent", sent_count, 3);

    @(negedge wclk);
    start = 1; len = 5; mode = 0; seed = 3;
    @(negedge wclk);
    start = 0;
    @(negedge wclk);
    @(negedge wclk);
    #1 check("pre_rst_sent", sent_count, 2);
    rst = 1;
    #1 check("mid_rst_we", we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_sent", sent_count, 0);
    check("mid_rst_chk", checksum, 0);
    check("mid_rst_data", data_out, 0);
    @(negedge wclk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge wclk);
      #1 check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end
    burst(5, 0, 4'd3, 0, 0, 0, ns, cs);
    check("post_rst_burst", sent_count, 5);

    for (int r = 0; r < 12; r++) begin
      int rl, rn, ra;
      rl = $urandom_range(15);
      rn = (rl == 0) ? 16 : rl;
      ra = ($urandom_range(3) == 0) ? $urandom_range(1, rn) : 0;
      burst(rl, $urandom_range(3), 4'($urandom_range(15)), 30, 0, ra, ns, cs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule
